// File: rtl/ebus_xact_pkg.sv
// Shared EBUS types: function codes, driver slot record, sequencer states,
// response error bit positions and the write-function classifier.
package ebus_xact_pkg;

    typedef enum logic [2:0] {
        ebusCONO     = 3'b000,
        ebusCONI     = 3'b001,
        ebusDATAO    = 3'b010,
        ebusDATAI    = 3'b011,
        ebusPIserved = 3'b100,
        ebusPIaddrIn = 3'b101
    } tEBUSfunction;

    typedef struct packed {
        logic        driving;
        logic [35:0] data;
    } tEBUSdriver;

    typedef enum logic [1:0] {
        xactIDLE    = 2'd0,
        xactDEMAND  = 2'd1,
        xactXFER    = 2'd2,
        xactRELEASE = 2'd3
    } tEBUSxactState;

    localparam int ebusRspErrTimeout    = 0;
    localparam int ebusRspErrContention = 1;

    // Only CONO and DATAO push data from the EBOX; every other code
    // (including the unnamed 110/111) is a read.
    function automatic logic isEBUSwrite(tEBUSfunction func);
        return (func == ebusCONO) || (func == ebusDATAO);
    endfunction

endpackage

// File: rtl/ebus_xact_if.sv
// Request/response handshake plus the shared EBUS lines seen by the
// transaction sequencer. slave = sequencer side, master = EBOX/bus side.
interface ebus_xact_if
    import ebus_xact_pkg::*;
#(
    parameter int NDEV = 8
);
    logic                    reqValid;
    logic                    reqReady;
    logic [6:0]              reqCS;
    tEBUSfunction            reqFunc;
    logic [35:0]             reqData;
    logic                    rspValid;
    logic [35:0]             rspData;
    logic [1:0]              rspErr;
    tEBUSdriver [NDEV-1:0]   drv;
    logic                    devAck;
    logic                    devXfer;
    logic [35:0]             ebusData;
    logic                    ebusParity;
    logic [6:0]              ebusCS;
    logic [2:0]              ebusFunc;
    logic                    ebusDemand;

    modport slave (
        input  reqValid, reqCS, reqFunc, reqData, drv, devAck, devXfer,
        output reqReady, rspValid, rspData, rspErr,
               ebusData, ebusParity, ebusCS, ebusFunc, ebusDemand
    );

    modport master (
        output reqValid, reqCS, reqFunc, reqData, drv, devAck, devXfer,
        input  reqReady, rspValid, rspData, rspErr,
               ebusData, ebusParity, ebusCS, ebusFunc, ebusDemand
    );

endinterface

// File: rtl/ebus_xact_drv_mux.sv
// NDEV-slot OR-mux of device drivers onto the EBUS data lines, with a
// contention flag (more than one slot driving) and an any-driving flag.
module ebus_drv_mux
    import ebus_xact_pkg::*;
#(
    parameter int NDEV = 8
) (
    input  tEBUSdriver [NDEV-1:0] drv_i,
    output logic [35:0]           data_o,
    output logic                  contention_o,
    output logic                  anyDriving_o
);

    // A second driving slot after one has already been seen means popcount > 1.
    always_comb begin
        data_o       = '0;
        contention_o = 1'b0;
        anyDriving_o = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (drv_i[i].driving) begin
                data_o       = data_o | drv_i[i].data;
                contention_o = contention_o | anyDriving_o;
                anyDriving_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_xact.sv
// EBOX-side EBUS transaction sequencer: one request at a time through
// demand/ack/xfer/release with per-phase timeouts, device data capture
// and status return.
module ebus_xact
    import ebus_xact_pkg::*;
#(
    parameter int NDEV    = 8,
    parameter int TIMEOUT = 255
) (
    input logic        clk,
    input logic        resetN,
    ebus_xact_if.slave bus
);

    tEBUSxactState state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [35:0]   rspData_q, rspData_d;
    logic [1:0]    err_q, err_d;
    logic [6:0]    cs_q;
    tEBUSfunction  func_q;
    logic [35:0]   wdata_q;

    logic [35:0]   muxData;
    logic          muxContention;
    logic          muxAny;
    logic          accept;
    logic          expired;
    logic          onBus;
    logic          isWrite;
    logic          capture;
    logic          relTimeout;
    logic          rspValid;

    ebus_drv_mux #(.NDEV(NDEV)) u_mux (
        .drv_i        (bus.drv),
        .data_o       (muxData),
        .contention_o (muxContention),
        .anyDriving_o (muxAny)
    );

    assign accept  = (state_q == xactIDLE) && bus.reqValid;
    // Timer holds cycles since phase entry, so equality marks cycle TIMEOUT+1.
    assign expired = (timer_q == 16'(TIMEOUT));
    assign onBus   = (state_q == xactDEMAND) || (state_q == xactXFER);
    assign isWrite = isEBUSwrite(func_q);

    // Control state: asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= xactIDLE;
            timer_q   <= '0;
            rspData_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rspData_q <= rspData_d;
            err_q     <= err_d;
        end
    end

    // Request fields are only meaningful while on the bus, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            cs_q    <= bus.reqCS;
            func_q  <= bus.reqFunc;
            wdata_q <= bus.reqData;
        end
    end

    // Next-state, timer and response bookkeeping; exit conditions beat timeouts.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 16'd1;
        rspData_d  = rspData_q;
        err_d      = err_q;
        capture    = 1'b0;
        relTimeout = 1'b0;
        rspValid   = 1'b0;
        unique case (state_q)
            xactIDLE: begin
                timer_d = '0;
                if (accept) begin
                    state_d   = xactDEMAND;
                    rspData_d = '0;
                    err_d     = '0;
                end
            end
            xactDEMAND: begin
                if (bus.devAck) begin
                    timer_d = '0;
                    if (bus.devXfer) begin
                        capture = 1'b1;
                        state_d = xactRELEASE;
                    end else begin
                        state_d = xactXFER;
                    end
                end else if (expired) begin
                    err_d[ebusRspErrTimeout] = 1'b1;
                    timer_d = '0;
                    state_d = xactRELEASE;
                end
            end
            xactXFER: begin
                if (bus.devXfer) begin
                    capture = 1'b1;
                    timer_d = '0;
                    state_d = xactRELEASE;
                end else if (expired) begin
                    err_d[ebusRspErrTimeout] = 1'b1;
                    timer_d = '0;
                    state_d = xactRELEASE;
                end
            end
            xactRELEASE: begin
                if (!bus.devAck && !bus.devXfer) begin
                    rspValid = 1'b1;
                    state_d  = xactIDLE;
                end else if (expired) begin
                    relTimeout = 1'b1;
                    err_d[ebusRspErrTimeout] = 1'b1;
                    rspValid = 1'b1;
                    state_d  = xactIDLE;
                end
            end
            default: state_d = xactIDLE;
        endcase
        // Reads keep the OR of all drivers; nothing driving leaves rspData at 0.
        if (capture) begin
            if (!isWrite && muxAny) begin
                rspData_d = muxData;
            end
            if (muxContention) begin
                err_d[ebusRspErrContention] = 1'b1;
            end
        end
    end

    assign bus.reqReady   = (state_q == xactIDLE);
    assign bus.rspValid   = rspValid;
    assign bus.rspData    = rspData_q;
    // A release timeout is reported in the same cycle as its rspValid pulse.
    assign bus.rspErr     = err_q | {1'b0, relTimeout};
    assign bus.ebusDemand = onBus;
    assign bus.ebusCS     = onBus ? cs_q : 7'd0;
    assign bus.ebusFunc   = onBus ? 3'(func_q) : 3'd0;
    assign bus.ebusData   = muxData | ((onBus && isWrite) ? wdata_q : 36'd0);
    assign bus.ebusParity = ~^bus.ebusData;

endmodule

// File: tb/tb_ebus_xact.sv
// Self-checking bench for ebus_xact: directed scenarios plus randomized
// transactions against a transaction-level model of the bus protocol.
module tb_ebus_xact;
    import ebus_xact_pkg::*;

    localparam int NDEV    = 8;
    localparam int TIMEOUT = 10;
    localparam int NMAX    = 64;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    ebus_xact_if #(.NDEV(NDEV)) bus ();

    ebus_xact #(.NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        ackS   [NMAX];
    logic        xferS  [NMAX];
    logic        expDem [NMAX];
    int          expValid;
    logic [35:0] expData;
    logic [1:0]  expErr;
    logic [35:0] lastData;
    logic [1:0]  lastErr;
    tEBUSdriver  drvArr [NDEV];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] rnd36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    task automatic script_clear();
        for (int c = 0; c < NMAX; c++) begin
            ackS[c]  = 1'b0;
            xferS[c] = 1'b0;
        end
    endtask

    task automatic script_set(input bit isXfer, input int from, input int len);
        for (int c = from; c < from + len && c < NMAX; c++) begin
            if (isXfer) xferS[c] = 1'b1;
            else        ackS[c]  = 1'b1;
        end
    endtask

    task automatic drv_clear();
        for (int i = 0; i < NDEV; i++) begin
            drvArr[i].driving = 1'b0;
            drvArr[i].data    = rnd36();
        end
    endtask

    // Protocol model over cycles 1.. after the accept edge: demand waits for ack
    // (ack+xfer together captures at once), xfer waits for devXfer, release waits
    // for both lines low; each wait aborts after TIMEOUT+1 cycles in that phase.
    task automatic model(input logic write, input logic [35:0] drvOr, input int nDrv);
        int phase;
        int start;
        for (int c = 0; c < NMAX; c++) expDem[c] = 1'b0;
        phase = 0; start = 1; expValid = -1; expData = '0; expErr = '0;
        for (int c = 1; c < NMAX && expValid < 0; c++) begin
            if (phase < 2) begin
                expDem[c] = 1'b1;
                if ((phase == 0 && ackS[c]) || (phase == 1 && xferS[c])) begin
                    if (xferS[c]) begin
                        if (!write) expData = drvOr;
                        if (nDrv > 1) expErr[1] = 1'b1;
                        phase = 2;
                    end else begin
                        phase = 1;
                    end
                    start = c + 1;
                end else if (c - start == TIMEOUT) begin
                    expErr[0] = 1'b1;
                    phase = 2;
                    start = c + 1;
                end
            end else begin
                if (!ackS[c] && !xferS[c]) begin
                    expValid = c;
                end else if (c - start == TIMEOUT) begin
                    expErr[0] = 1'b1;
                    expValid = c;
                end
            end
        end
    endtask

    // Entered just after a rising edge with the DUT idle; runs one transaction.
    task automatic run_txn(input tEBUSfunction f, input logic [6:0] cs,
                           input logic [35:0] d, input bit hold);
        logic        write;
        logic [35:0] drvOr;
        logic [35:0] expBus;
        int          nDrv;
        write = (f == ebusCONO) || (f == ebusDATAO);
        drvOr = '0;
        nDrv  = 0;
        for (int i = 0; i < NDEV; i++) begin
            bus.drv[i] = drvArr[i];
            if (drvArr[i].driving) begin
                drvOr = drvOr | drvArr[i].data;
                nDrv++;
            end
        end
        model(write, drvOr, nDrv);
        bus.reqFunc  = f;
        bus.reqCS    = cs;
        bus.reqData  = d;
        bus.reqValid = 1'b1;
        bus.devAck   = 1'b0;
        bus.devXfer  = 1'b0;
        @(negedge clk);
        chk("idle_ready",   64'(bus.reqReady),   64'(1));
        chk("idle_demand",  64'(bus.ebusDemand), 64'(0));
        chk("idle_rspData", 64'(bus.rspData),    64'(lastData));
        chk("idle_rspErr",  64'(bus.rspErr),     64'(lastErr));
        @(posedge clk); #1;
        if (!hold) bus.reqValid = 1'b0;
        if (expValid < 0) chk("model_bound", 64'(0), 64'(1));
        for (int c = 1; c <= expValid; c++) begin
            bus.devAck  = ackS[c];
            bus.devXfer = xferS[c];
            @(negedge clk);
            expBus = drvOr | ((expDem[c] && write) ? d : 36'd0);
            chk("demand",   64'(bus.ebusDemand), 64'(expDem[c]));
            chk("ebusCS",   64'(bus.ebusCS),     64'(expDem[c] ? cs : 7'd0));
            chk("ebusFunc", 64'(bus.ebusFunc),   64'(expDem[c] ? 3'(f) : 3'd0));
            chk("ebusData", 64'(bus.ebusData),   64'(expBus));
            chk("parity",   64'(bus.ebusParity), 64'(($countones(expBus) % 2) == 0));
            chk("busy_ready", 64'(bus.reqReady), 64'(0));
            chk("rspValid", 64'(bus.rspValid),   64'(c == expValid));
            if (c == expValid) begin
                chk("rspData", 64'(bus.rspData), 64'(expData));
                chk("rspErr",  64'(bus.rspErr),  64'(expErr));
            end
            @(posedge clk); #1;
        end
        bus.devAck  = 1'b0;
        bus.devXfer = 1'b0;
        lastData = expData;
        lastErr  = expErr;
    endtask

    task automatic reset_in_xfer();
        drv_clear();
        for (int i = 0; i < NDEV; i++) bus.drv[i] = drvArr[i];
        bus.reqFunc  = ebusDATAI;
        bus.reqCS    = 7'h22;
        bus.reqData  = '0;
        bus.reqValid = 1'b1;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        bus.devAck   = 1'b1;
        @(posedge clk); #1;
        #2;
        chk("rst_pre_demand", 64'(bus.ebusDemand), 64'(1));
        resetN = 1'b0;
        #1;
        chk("rst_demand",   64'(bus.ebusDemand), 64'(0));
        chk("rst_rspValid", 64'(bus.rspValid),   64'(0));
        bus.devAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_after_valid", 64'(bus.rspValid), 64'(0));
            chk("rst_after_ready", 64'(bus.reqReady), 64'(1));
            chk("rst_after_err",   64'(bus.rspErr),   64'(0));
        end
        @(posedge clk); #1;
        lastData = '0;
        lastErr  = '0;
    endtask

    initial begin
        tEBUSfunction f;
        int a;
        int xOn;
        bus.reqValid = 1'b0;
        bus.reqCS    = '0;
        bus.reqFunc  = ebusCONO;
        bus.reqData  = '0;
        bus.devAck   = 1'b0;
        bus.devXfer  = 1'b0;
        drv_clear();
        for (int i = 0; i < NDEV; i++) bus.drv[i] = drvArr[i];
        lastData = '0;
        lastErr  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",    64'(bus.reqReady),   64'(1));
        chk("reset_valid",    64'(bus.rspValid),   64'(0));
        chk("reset_demand",   64'(bus.ebusDemand), 64'(0));
        chk("reset_rspData",  64'(bus.rspData),    64'(0));
        chk("reset_rspErr",   64'(bus.rspErr),     64'(0));
        chk("reset_ebusData", 64'(bus.ebusData),   64'(0));
        chk("reset_ebusCS",   64'(bus.ebusCS),     64'(0));
        @(posedge clk); #1;
        resetN = 1'b1;

        // DATAO, device acks and xfers together in cycle 2
        drv_clear(); script_clear(); script_set(0, 2, 1); script_set(1, 2, 1);
        run_txn(ebusDATAO, 7'h01, 36'o123456701234, 1'b0);
        // DATAI, slot 3 driving, ack/xfer five cycles late
        drv_clear(); script_clear(); script_set(0, 7, 1); script_set(1, 7, 1);
        drvArr[3].driving = 1'b1; drvArr[3].data = 36'o777000111222;
        run_txn(ebusDATAI, 7'h05, 36'd0, 1'b0);
        // CONI with two drivers: contention, data still ORed
        drv_clear(); script_clear(); script_set(0, 2, 1); script_set(1, 2, 1);
        drvArr[0].driving = 1'b1; drvArr[0].data = 36'o1;
        drvArr[5].driving = 1'b1; drvArr[5].data = 36'o2;
        run_txn(ebusCONI, 7'h10, 36'd0, 1'b0);
        // No ack at all: demand timeout
        drv_clear(); script_clear();
        run_txn(ebusCONI, 7'h11, 36'd0, 1'b0);
        // Ack+xfer exactly in the timeout cycle: exit wins
        drv_clear(); script_clear(); script_set(0, TIMEOUT + 1, 1); script_set(1, TIMEOUT + 1, 1);
        run_txn(ebusDATAI, 7'h12, 36'd0, 1'b0);
        // Xfer held for 8 cycles with reqValid held throughout
        drv_clear(); script_clear(); script_set(0, 2, 1); script_set(1, 2, 8);
        drvArr[1].driving = 1'b1; drvArr[1].data = 36'o555;
        run_txn(ebusDATAI, 7'h13, 36'd0, 1'b1);
        // Xfer held for 20 cycles: release phase times out
        drv_clear(); script_clear(); script_set(0, 2, 1); script_set(1, 2, 20);
        run_txn(ebusCONO, 7'h14, 36'o42, 1'b0);
        // Unnamed code 110 treated as a read
        drv_clear(); script_clear(); script_set(0, 1, 2); script_set(1, 2, 1);
        drvArr[6].driving = 1'b1; drvArr[6].data = 36'o246;
        run_txn(tEBUSfunction'(3'b110), 7'h15, 36'o7777, 1'b0);

        reset_in_xfer();

        for (int t = 0; t < 150; t++) begin
            drv_clear();
            for (int i = 0; i < NDEV; i++) drvArr[i].driving = ($urandom_range(3, 0) == 0);
            script_clear();
            if ($urandom_range(9, 0) != 0) begin
                a   = $urandom_range(14, 1);
                xOn = a + $urandom_range(3, 0);
                script_set(0, a, $urandom_range(4, 1));
                script_set(1, xOn, ($urandom_range(7, 0) == 0) ? $urandom_range(20, 10)
                                                                : $urandom_range(3, 1));
            end
            f = tEBUSfunction'(3'($urandom_range(7, 0)));
            run_txn(f, 7'($urandom_range(127, 0)), rnd36(), ($urandom_range(4, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
